// File: rtl/data_bus_responder.sv
// data_bus_responder: data-bus slave serving a word-addressed RAM plus an I/O
// window with a free-running cycle counter and an output FIFO drained by a
// valid/ready consumer. Reads are combinational, writes take effect at posedge.
module data_bus_responder #(
  parameter int MEM_WORDS_LOG2  = 8,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int MEM_WORDS  = 1 << MEM_WORDS_LOG2;
  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;

  // Word addresses (byte address >> 2) of the I/O registers at 0xFFFF_0000..08.
  localparam logic [29:0] CYCLE_WORD  = 30'h3FFF_C000;
  localparam logic [29:0] FIFO_WORD   = 30'h3FFF_C001;
  localparam logic [29:0] STATUS_WORD = 30'h3FFF_C002;

  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_COUNT = FIFO_DEPTH;
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE    = 1;
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = 1;

  // Storage and state
  logic [31:0]                r_mem  [MEM_WORDS];
  logic [31:0]                r_fifo [FIFO_DEPTH];
  logic [31:0]                r_cycle;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic                       r_overflow;

  // Decode and handshake terms
  logic                      w_is_ram;
  logic                      w_is_cycle;
  logic                      w_is_fifo;
  logic                      w_is_status;
  logic [MEM_WORDS_LOG2-1:0] w_ram_idx;
  logic                      w_empty;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_push_req;
  logic                      w_push_ok;
  logic                      w_ovf_set;
  logic                      w_ovf_clr;
  logic [31:0]               w_status;
  logic [31:0]               w_rdata;
  logic                      w_unused_byte_offset;

  // The byte offset never selects anything: all accesses are whole words.
  assign w_unused_byte_offset = ^address_to_mem[1:0];

  assign w_is_ram    = (address_to_mem[31:16] == 16'h0000);
  assign w_is_cycle  = (address_to_mem[31:2] == CYCLE_WORD);
  assign w_is_fifo   = (address_to_mem[31:2] == FIFO_WORD);
  assign w_is_status = (address_to_mem[31:2] == STATUS_WORD);
  // Upper bits of the RAM region are dropped, so the RAM aliases across it.
  assign w_ram_idx   = address_to_mem[MEM_WORDS_LOG2+1:2];

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_COUNT);
  assign w_pop      = out_valid && out_ready;
  assign w_push_req = WE && w_is_fifo;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && !w_push_ok;
  assign w_ovf_clr  = WE && w_is_status && data_to_mem[2];

  assign w_status = 32'({r_count, r_overflow, w_full, w_empty});

  assign out_valid     = !w_empty;
  assign out_data      = w_empty ? 32'h0 : r_fifo[r_rd_ptr];
  assign data_from_mem = w_rdata;

  // Read mux: RAM, counter or status; everything else reads as zero.
  always_comb begin
    // NOTE: default assigned first so every path drives w_rdata and no latch is inferred.
    w_rdata = 32'h0;
    if (w_is_ram) begin
      w_rdata = r_mem[w_ram_idx];
    end else if (w_is_cycle) begin
      w_rdata = r_cycle;
    end else if (w_is_status) begin
      w_rdata = w_status;
    end
  end

  // RAM write port; contents survive reset, but a write during reset is dropped.
  always_ff @(posedge clk) begin
    // NOTE: arrays of storage carry no reset so they map onto plain RAM cells.
    if (!reset && WE && w_is_ram) begin
      r_mem[w_ram_idx] <= data_to_mem;
    end
  end

  // Cycle counter: a bus write loads it, otherwise it counts and wraps.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_cycle <= 32'h0;
    end else if (WE && w_is_cycle) begin
      r_cycle <= data_to_mem;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  // FIFO data slots, written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) begin
      r_fifo[r_wr_ptr] <= data_to_mem;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag: a dropped push sets it and wins over a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (w_ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Testbench for data_bus_responder: a directed vector table, hand-written
// FIFO/reset sequences and a randomized phase compared against a queue-based
// reference model of the bus-visible behaviour.
module tb_data_bus_responder;

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
  localparam logic [31:0] A_FIFO   = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam int          RAM_WORDS = 256;
  localparam int          FIFO_MAX  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  data_bus_responder dut (
    .clk            (clk),
    .reset          (reset),
    .WE             (WE),
    .address_to_mem (address_to_mem),
    .data_to_mem    (data_to_mem),
    .data_from_mem  (data_from_mem),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_ram       [RAM_WORDS];
  bit          m_ram_known [RAM_WORDS];
  logic [31:0] m_cycle;
  logic [31:0] m_fifo [$];
  bit          m_ovf;

  // Apply the currently driven inputs to the model, as the coming edge will.
  task automatic model_edge();
    int  idx;
    bit  pop, push, full;
    if (reset) begin
      m_cycle = 0;
      m_fifo.delete();
      m_ovf = 0;
      return;
    end
    idx  = int'((address_to_mem >> 2) % RAM_WORDS);
    pop  = (m_fifo.size() > 0) && out_ready;
    push = WE && (address_to_mem >> 2 == A_FIFO >> 2);
    full = (m_fifo.size() == FIFO_MAX);
    if (WE && (address_to_mem >> 16 == 0)) begin
      m_ram[idx] = data_to_mem;
      m_ram_known[idx] = 1;
    end
    if (WE && (address_to_mem >> 2 == A_CYCLE >> 2)) m_cycle = data_to_mem;
    else m_cycle = m_cycle + 1;
    if (pop) void'(m_fifo.pop_front());
    if (push && full && !pop) m_ovf = 1;
    else begin
      if (push) m_fifo.push_back(data_to_mem);
      if (WE && (address_to_mem >> 2 == A_STATUS >> 2) && data_to_mem[2]) m_ovf = 0;
    end
  endtask

  // Expected read data; bit 32 says whether the value is known.
  function automatic logic [32:0] model_read(input logic [31:0] a);
    int n;
    n = m_fifo.size();
    if (a >> 16 == 0) begin
      int idx;
      idx = int'((a >> 2) % RAM_WORDS);
      return {m_ram_known[idx], m_ram_known[idx] ? m_ram[idx] : 32'h0};
    end
    if (a >> 2 == A_CYCLE >> 2) return {1'b1, m_cycle};
    if (a >> 2 == A_STATUS >> 2)
      return {1'b1, 32'(n * 8 + (m_ovf ? 4 : 0) + (n == FIFO_MAX ? 2 : 0) + (n == 0 ? 1 : 0))};
    return {1'b1, 32'h0};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy);
    WE = we; address_to_mem = a; data_to_mem = d; out_ready = rdy;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [32:0] r;
    r = model_read(address_to_mem);
    if (r[32]) check({tag, " rdata"}, data_from_mem, r[31:0]);
    check({tag, " valid"}, 32'(out_valid), 32'(m_fifo.size() != 0));
    check({tag, " odata"}, out_data, (m_fifo.size() != 0) ? m_fifo[0] : 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic [31:0] exp_odata;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input bit chk, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.rdy = 1'b0;
    v.chk_rd = chk; v.exp_rd = exp; v.exp_valid = 1'b0; v.exp_odata = 32'h0;
    return v;
  endfunction

  vec_t vecs [16];

  initial begin
    // Directed table, starting the first cycle after reset deasserts.
    vecs[0]  = mk(0, A_CYCLE, 0, 1, 32'h0000_0000);
    vecs[1]  = mk(0, A_CYCLE, 0, 1, 32'h0000_0001);
    vecs[2]  = mk(0, A_CYCLE, 0, 1, 32'h0000_0002);
    vecs[3]  = mk(1, A_CYCLE, 32'hFFFF_FFFE, 1, 32'h0000_0003);
    vecs[4]  = mk(0, A_CYCLE, 0, 1, 32'hFFFF_FFFE);
    vecs[5]  = mk(0, A_CYCLE, 0, 1, 32'hFFFF_FFFF);
    vecs[6]  = mk(0, A_CYCLE, 0, 1, 32'h0000_0000);
    vecs[7]  = mk(1, 32'h0000_0010, 32'h1111_1111, 0, 32'h0);
    vecs[8]  = mk(1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 32'h1111_1111);
    vecs[9]  = mk(0, 32'h0000_0010, 0, 1, 32'hDEAD_BEEF);
    vecs[10] = mk(0, 32'h0000_0013, 0, 1, 32'hDEAD_BEEF);
    vecs[11] = mk(0, 32'h0000_0410, 0, 1, 32'hDEAD_BEEF);
    vecs[12] = mk(0, 32'h0001_0010, 0, 1, 32'h0000_0000);
    vecs[13] = mk(0, A_STATUS, 0, 1, 32'h0000_0001);
    vecs[14] = mk(0, A_FIFO, 0, 1, 32'h0000_0000);
    vecs[15] = mk(1, 32'hFFFF_000C, 32'h1234_5678, 1, 32'h0000_0000);

    foreach (m_ram_known[i]) m_ram_known[i] = 0;
    m_ovf = 0;
    m_cycle = 0;
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdy);
      if (vecs[i].chk_rd) check($sformatf("vec%0d rdata", i), data_from_mem, vecs[i].exp_rd);
      check($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d odata", i), out_data, vecs[i].exp_odata);
      tick();
    end

    // FIFO fill and overflow with the consumer stalled.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, A_FIFO, 32'(k), 1'b0);
      tick();
    end
    drive(1'b0, A_STATUS, 0, 1'b0);
    check("fill status", data_from_mem, 32'h22);
    check("fill head", out_data, 32'h1);
    drive(1'b1, A_FIFO, 32'h5, 1'b0);
    tick();
    drive(1'b0, A_STATUS, 0, 1'b0);
    check("ovf status", data_from_mem, 32'h26);
    drive(1'b1, A_STATUS, 32'h4, 1'b0);
    tick();
    drive(1'b0, A_STATUS, 0, 1'b0);
    check("ovf clear", data_from_mem, 32'h22);

    // Push while popping a full FIFO, then drain in order.
    drive(1'b1, A_FIFO, 32'h9, 1'b1);
    check("drain 1", out_data, 32'h1);
    tick();
    drive(1'b0, A_STATUS, 0, 1'b1);
    check("pushpop status", data_from_mem, 32'h22);
    check("drain 2", out_data, 32'h2);
    tick();
    check("drain 3", out_data, 32'h3);
    tick();
    check("drain 4", out_data, 32'h4);
    tick();
    check("drain 9", out_data, 32'h9);
    tick();
    drive(1'b0, A_STATUS, 0, 1'b0);
    check("empty valid", 32'(out_valid), 32'h0);
    check("empty odata", out_data, 32'h0);
    check("empty status", data_from_mem, 32'h01);

    // Reset in the middle of activity, together with a push.
    drive(1'b1, A_FIFO, 32'hA, 1'b0);
    tick();
    drive(1'b1, A_FIFO, 32'hB, 1'b0);
    tick();
    drive(1'b1, A_CYCLE, 32'd100, 1'b0);
    tick();
    drive(1'b0, A_CYCLE, 0, 1'b0);
    check("pre-reset cycle", data_from_mem, 32'd100);
    check("pre-reset valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    drive(1'b1, A_FIFO, 32'hC, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, A_STATUS, 0, 1'b0);
    check("rst status", data_from_mem, 32'h01);
    check("rst valid", 32'(out_valid), 32'h0);
    check("rst odata", out_data, 32'h0);
    drive(1'b0, A_CYCLE, 0, 1'b0);
    check("rst cycle 0", data_from_mem, 32'h0);
    tick();
    check("rst cycle 1", data_from_mem, 32'h1);
    drive(1'b0, 32'h0000_0010, 0, 1'b0);
    check("rst ram kept", data_from_mem, 32'hDEAD_BEEF);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      int          sel;
      sel = $urandom_range(0, 9);
      d   = $urandom;
      case (sel)
        0, 1, 2, 3: a = {16'h0000, 6'($urandom), 8'($urandom_range(0, 15)), 2'($urandom)};
        4:          a = A_CYCLE | 32'($urandom_range(0, 3));
        5, 6:       a = A_FIFO;
        7:          a = A_STATUS;
        8:          a = 32'hFFFF_000C + 32'($urandom_range(0, 64) * 4);
        default:    a = {16'($urandom_range(1, 16'hFFFE)), 16'($urandom)};
      endcase
      reset = ($urandom_range(0, 99) == 0);
      drive(1'($urandom), a, d, 1'($urandom));
      check_model($sformatf("rnd%0d", n));
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
